// File: rtl/id_decode_stage_pkg.sv
// id_decode_stage_pkg: instruction field positions and default widths shared by the decode stage.
package id_decode_stage_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_IMM_WIDTH = 16;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2**AW x DW register file, r0 hardwired to zero, two async reads with write-through bypass.
module regfile_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic                  wr_ok;
  assign wr_ok = we_i & ~rstb & (waddr_i != '0);
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_a_o = (raddr_a_i == '0) ? '0 : (wr_ok && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : (wr_ok && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: register read, immediate extension, load-use hazard detection and ID/EX pipeline register.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int IMM_WIDTH  = DEF_IMM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] pc_plus4_in,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  ext_ctrl,
  input  logic                  rt_used,
  input  logic                  reg_wr_en,
  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic                  ex_mem_read,
  input  logic [ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                  flush,
  output logic                  stall_out,
  output logic [ADDR_WIDTH-1:0] regS_addr_id,
  output logic [ADDR_WIDTH-1:0] regT_addr_id,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] pc_plus4_out,
  output logic [DATA_WIDTH-1:0] regA_rd_data,
  output logic [DATA_WIDTH-1:0] regB_rd_data,
  output logic [DATA_WIDTH-1:0] imm_exted,
  output logic [ADDR_WIDTH-1:0] regS_addr,
  output logic [ADDR_WIDTH-1:0] regT_addr,
  output logic [ADDR_WIDTH-1:0] regD_addr
);
  localparam int unused_field_msbs = RS_MSB + RT_MSB + RD_MSB;
  logic                  unused_opcode;
  logic [ADDR_WIDTH-1:0] rs, rt, rd;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b, imm;
  logic [IMM_WIDTH-1:0]  imm_raw;
  logic                  hazard, ld;
  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] pc_d, pc_q, ra_d, ra_q, rb_d, rb_q, imm_d, imm_q;
  logic [ADDR_WIDTH-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  assign unused_opcode = ^instr_in[DATA_WIDTH-1:RS_MSB+1];
  assign rs = instr_in[RS_LSB +: ADDR_WIDTH];
  assign rt = instr_in[RT_LSB +: ADDR_WIDTH];
  assign rd = instr_in[RD_LSB +: ADDR_WIDTH];
  assign imm_raw = instr_in[IMM_WIDTH-1:0];
  assign imm = {{(DATA_WIDTH-IMM_WIDTH){ext_ctrl & imm_raw[IMM_WIDTH-1]}}, imm_raw};
  assign regS_addr_id = rs;
  assign regT_addr_id = rt;
  regfile_bypass #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rf (
    .clk       (clk),
    .rstb      (rstb),
    .we_i      (reg_wr_en),
    .waddr_i   (reg_wr_addr),
    .wdata_i   (reg_wr_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );
  assign hazard = in_valid & ex_mem_read & (ex_rd_addr != '0) &
                  ((ex_rd_addr == rs) | (rt_used & (ex_rd_addr == rt)));
  assign stall_out = hazard & ~flush;
  // A flush still loads the fields (they are don't-care once invalid); only a real stall holds them.
  assign ld = flush | ~hazard;
  always_comb begin
    valid_d = in_valid & ~flush & ~hazard;
    pc_d    = ld ? pc_plus4_in : pc_q;
    ra_d    = ld ? rdata_a : ra_q;
    rb_d    = ld ? rdata_b : rb_q;
    imm_d   = ld ? imm : imm_q;
    rs_d    = ld ? rs : rs_q;
    rt_d    = ld ? rt : rt_q;
    rd_d    = ld ? rd : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rstb) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end
  assign out_valid    = valid_q;
  assign pc_plus4_out = pc_q;
  assign regA_rd_data = ra_q;
  assign regB_rd_data = rb_q;
  assign imm_exted    = imm_q;
  assign regS_addr    = rs_q;
  assign regT_addr    = rt_q;
  assign regD_addr    = rd_q;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed self-checking bench for id_decode_stage.
module tb_id_decode_stage;
  logic        clk = 1'b0;
  logic        rstb, in_valid, ext_ctrl, rt_used, reg_wr_en, ex_mem_read, flush;
  logic [31:0] pc_plus4_in, instr_in, reg_wr_data;
  logic [4:0]  reg_wr_addr, ex_rd_addr;
  logic        stall_out, out_valid;
  logic [4:0]  regS_addr_id, regT_addr_id, regS_addr, regT_addr, regD_addr;
  logic [31:0] pc_plus4_out, regA_rd_data, regB_rd_data, imm_exted;
  int          n_chk = 0;
  int          n_pass = 0;
  always #5 clk = ~clk;
  id_decode_stage dut (
    .clk          (clk),
    .rstb         (rstb),
    .in_valid     (in_valid),
    .pc_plus4_in  (pc_plus4_in),
    .instr_in     (instr_in),
    .ext_ctrl     (ext_ctrl),
    .rt_used      (rt_used),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .ex_mem_read  (ex_mem_read),
    .ex_rd_addr   (ex_rd_addr),
    .flush        (flush),
    .stall_out    (stall_out),
    .regS_addr_id (regS_addr_id),
    .regT_addr_id (regT_addr_id),
    .out_valid    (out_valid),
    .pc_plus4_out (pc_plus4_out),
    .regA_rd_data (regA_rd_data),
    .regB_rd_data (regB_rd_data),
    .imm_exted    (imm_exted),
    .regS_addr    (regS_addr),
    .regT_addr    (regT_addr),
    .regD_addr    (regD_addr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    in_valid = v; pc_plus4_in = pc; instr_in = ins;
    reg_wr_en = we; reg_wr_addr = wa; reg_wr_data = wd;
  endtask
  initial begin
    rstb = 1'b1; in_valid = 0; pc_plus4_in = 0; instr_in = 0; ext_ctrl = 0; rt_used = 0;
    reg_wr_en = 0; reg_wr_addr = 0; reg_wr_data = 0; ex_mem_read = 0; ex_rd_addr = 0; flush = 0;
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_pc", pc_plus4_out, 0);
    check("rst_regA", regA_rd_data, 0);
    check("rst_imm", imm_exted, 0);
    drive(0, 0, 0, 0, 0, 0);
    rstb = 0;
    // write r5 then read it as rs
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
    tick();
    drive(1, 32'h104, mk(5, 0, 16'h0010), 0, 0, 0);
    #1 check("rs_id_comb", {27'd0, regS_addr_id}, 5);
    tick();
    check("r5_regA", regA_rd_data, 32'hDEADBEEF);
    check("r5_valid", {31'd0, out_valid}, 1);
    check("r5_pc", pc_plus4_out, 32'h104);
    check("r5_regS", {27'd0, regS_addr}, 5);
    // same-cycle write of r7 bypassed to rt read
    drive(1, 32'h108, mk(5, 7, 16'h0020), 1, 7, 32'h1234);
    #1 check("rt_id_comb", {27'd0, regT_addr_id}, 7);
    tick();
    check("byp_regB", regB_rd_data, 32'h00001234);
    check("byp_regA", regA_rd_data, 32'hDEADBEEF);
    check("byp_regT", {27'd0, regT_addr}, 7);
    // r0 write discarded, and not bypassed
    drive(0, 0, 0, 1, 0, 32'hFFFFFFFF);
    tick();
    drive(1, 32'h10C, mk(0, 0, 16'h0000), 1, 0, 32'hFFFFFFFF);
    tick();
    check("r0_regA", regA_rd_data, 0);
    check("r0_regB", regB_rd_data, 0);
    // hazard gating (combinational only)
    drive(1, 32'h110, mk(2, 9, 16'h0), 0, 0, 0);
    ex_mem_read = 1; ex_rd_addr = 9; rt_used = 0;
    #1 check("haz_rt_unused", {31'd0, stall_out}, 0);
    rt_used = 1;
    #1 check("haz_rt_used", {31'd0, stall_out}, 1);
    in_valid = 0;
    #1 check("haz_invalid", {31'd0, stall_out}, 0);
    in_valid = 1; instr_in = mk(0, 0, 16'h0); ex_rd_addr = 0;
    #1 check("haz_r0", {31'd0, stall_out}, 0);
    ex_mem_read = 0; rt_used = 0;
    // load-use stall: prior instruction, then stall, then reissue
    drive(1, 32'h1F0, mk(5, 1, 16'h0042), 0, 0, 0);
    tick();
    drive(1, 32'h200, mk(3, 1, 16'h0099), 1, 3, 32'hCAFE);
    ex_mem_read = 1; ex_rd_addr = 3;
    #1 check("ld_stall", {31'd0, stall_out}, 1);
    tick();
    check("ld_bubble_valid", {31'd0, out_valid}, 0);
    check("ld_hold_pc", pc_plus4_out, 32'h1F0);
    check("ld_hold_regS", {27'd0, regS_addr}, 5);
    check("ld_hold_imm", imm_exted, 32'h42);
    drive(1, 32'h200, mk(3, 1, 16'h0099), 0, 0, 0);
    ex_mem_read = 0;
    #1 check("ld_nostall", {31'd0, stall_out}, 0);
    tick();
    check("ld_reissue_valid", {31'd0, out_valid}, 1);
    check("ld_reissue_pc", pc_plus4_out, 32'h200);
    check("ld_reissue_regA", regA_rd_data, 32'hCAFE);
    // hazard with flush, negative imm sign-extended
    drive(1, 32'h300, mk(4, 0, 16'h8000), 0, 0, 0);
    ex_mem_read = 1; ex_rd_addr = 4; flush = 1; ext_ctrl = 1;
    #1 check("flush_stall", {31'd0, stall_out}, 0);
    tick();
    check("flush_valid", {31'd0, out_valid}, 0);
    check("imm_sext", imm_exted, 32'hFFFF8000);
    check("flush_pc", pc_plus4_out, 32'h300);
    drive(1, 32'h304, mk(4, 0, 16'h8000), 0, 0, 0);
    ex_mem_read = 0; flush = 0; ext_ctrl = 0;
    tick();
    check("imm_zext", imm_exted, 32'h00008000);
    check("norm_valid", {31'd0, out_valid}, 1);
    check("norm_rd", {27'd0, regD_addr}, 16);
    // reset after writes, with a write attempted during reset
    drive(0, 0, 0, 1, 6, 32'h66);
    tick();
    drive(1, 32'h400, mk(6, 6, 16'h1234), 1, 6, 32'h77);
    rstb = 1;
    tick();
    check("rst2_valid", {31'd0, out_valid}, 0);
    check("rst2_pc", pc_plus4_out, 0);
    check("rst2_regA", regA_rd_data, 0);
    check("rst2_regB", regB_rd_data, 0);
    check("rst2_imm", imm_exted, 0);
    check("rst2_addr", {17'd0, regS_addr, regT_addr, regD_addr}, 0);
    drive(0, 0, 0, 0, 0, 0);
    rstb = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1, 32'h500, mk(5'(i), 5'(31 - i), 16'h0), 0, 0, 0);
      tick();
      check($sformatf("clr_r%0d", i), regA_rd_data | regB_rd_data, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
